// File: rtl/neo_engine_if.sv
// neo_engine_if: frame control, sample RAM read port,
// result RAM write port and frame status of the NEO engine.
interface neo_engine_if #(
  parameter int N    = 16,
  parameter int M    = 32,
  parameter int KMAX = 4,
  parameter int OW   = 2*N
);
  localparam int AW = $clog2(M);
  localparam int KW = $clog2(KMAX+1);
  localparam int CW = $clog2(M+1);

  logic                 start;
  logic [KW-1:0]        k;
  logic signed [OW-1:0] thresh;
  logic [AW-1:0]        raddr;
  logic signed [N-1:0]  rdata;
  logic                 wen;
  logic [AW-1:0]        waddr;
  logic signed [OW-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        spike_count;
  logic                 sat;

  modport master (
    output start, k, thresh, rdata,
    input  raddr, wen, waddr, wdata,
    input  busy, done, spike_count, sat
  );

  modport slave (
    input  start, k, thresh, rdata,
    output raddr, wen, waddr, wdata,
    output busy, done, spike_count, sat
  );
endinterface

// File: rtl/neo_engine.sv
// neo_engine: lag-k nonlinear energy operator over one frame.
// Streams M samples, writes saturated psi[n], counts spikes.
module neo_engine #(
  parameter int N    = 16,
  parameter int M    = 32,
  parameter int KMAX = 4,
  parameter int OW   = 2*N
) (
  input logic         Clk,
  input logic         reset,
  neo_engine_if.slave bus
);
  localparam int AW = $clog2(M);
  localparam int KW = $clog2(KMAX+1);
  localparam int CW = $clog2(M+1);
  localparam int SW = $clog2(M+KMAX+1);
  localparam int HL = 2*KMAX+1;
  localparam int PW = 2*N;

  localparam logic signed [PW:0] SMAX =
    {{(PW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } st_t;

  st_t                  st;
  logic [KW-1:0]        kin;
  logic [KW-1:0]        kl;
  logic signed [OW-1:0] thr;
  logic [AW-1:0]        raddr;
  logic                 rv;
  logic [KW-1:0]        zl;
  logic [SW-1:0]        sc;
  logic                 sh;
  logic                 cv;
  logic [AW-1:0]        wc;
  logic                 wen;
  logic [AW-1:0]        waddr;
  logic signed [OW-1:0] wdata;
  logic                 done;
  logic [CW-1:0]        scnt;
  logic                 sat;

  logic signed [N-1:0]  hs [HL];
  logic [HL-1:0]        hv;

  logic signed [N-1:0]  xc;
  logic signed [N-1:0]  xp;
  logic                 vp;
  logic signed [PW-1:0] p0;
  logic signed [PW-1:0] p1;
  logic signed [PW:0]   df;
  logic signed [PW:0]   ps;
  logic signed [OW-1:0] y;
  logic                 ov;

  always_comb begin
    kin = bus.k;
    unique case (1'b1)
      (bus.k == '0):        kin = KW'(1);
      (32'(bus.k) > KMAX):  kin = KW'(KMAX);
      default:              kin = bus.k;
    endcase
  end

  // hs[0] is x[n+k], hs[k] is x[n], hs[2k] is x[n-k]
  always_comb begin
    xc = '0;
    xp = '0;
    vp = 1'b0;
    for (int i = 1; i <= KMAX; i++) begin
      if (32'(kl) == i) begin
        xc = hs[i];
        xp = hs[2*i];
        vp = hv[2*i];
      end
    end
  end

  assign p0 = PW'(xc) * PW'(xc);
  assign p1 = PW'(hs[0]) * PW'(xp);
  assign df = (PW+1)'(p0) - (PW+1)'(p1);

  always_comb begin
    ps = df;
    if (!(hv[0] && vp)) ps = '0;
    y  = ps[OW-1:0];
    ov = 1'b0;
    if (ps > SMAX) begin
      y  = SMAX[OW-1:0];
      ov = 1'b1;
    end else if (ps < SMIN) begin
      y  = SMIN[OW-1:0];
      ov = 1'b1;
    end
  end

  // k zero samples follow the last real sample in FLUSH
  assign sh = rv || (st == FLUSH && zl != '0);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      kl    <= '0;
      thr   <= '0;
      raddr <= '0;
      rv    <= 1'b0;
      zl    <= '0;
      sc    <= '0;
      cv    <= 1'b0;
      wc    <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
      scnt  <= '0;
      sat   <= 1'b0;
      hv    <= '0;
      for (int i = 0; i < HL; i++) hs[i] <= '0;
    end else begin
      done <= 1'b0;
      wen  <= cv;
      rv   <= (st == RUN);
      cv   <= sh && (sc >= SW'(kl));
      if (sh) begin
        for (int i = HL-1; i > 0; i--) hs[i] <= hs[i-1];
        hs[0] <= rv ? bus.rdata : '0;
        hv    <= {hv[HL-2:0], rv};
        sc    <= sc + SW'(1);
        if (!rv) zl <= zl - KW'(1);
      end
      if (cv) begin
        waddr <= wc;
        wdata <= y;
        wc    <= wc + AW'(1);
        if (ov) sat <= 1'b1;
      end
      if (wen && wdata > thr) scnt <= scnt + CW'(1);
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            st   <= RUN;
            kl   <= kin;
            thr  <= bus.thresh;
            zl   <= kin;
            sc   <= '0;
            wc   <= '0;
            scnt <= '0;
            sat  <= 1'b0;
            hv   <= '0;
            for (int i = 0; i < HL; i++) hs[i] <= '0;
          end
        end
        RUN: begin
          if (raddr == AW'(M-1)) st <= FLUSH;
          else raddr <= raddr + AW'(1);
        end
        FLUSH: begin
          if (wen && waddr == AW'(M-1)) begin
            st    <= IDLE;
            raddr <= '0;
            done  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.raddr       = raddr;
  assign bus.wen         = wen;
  assign bus.waddr       = waddr;
  assign bus.wdata       = wdata;
  assign bus.busy        = (st != IDLE);
  assign bus.done        = done;
  assign bus.spike_count = scnt;
  assign bus.sat         = sat;
endmodule

// File: tb/tb_neo_engine.sv
// tb_neo_engine: directed frames against two engines
// (OW = 32 and OW = 16) sharing one sample memory image.
module tb_neo_engine;
  localparam int N    = 16;
  localparam int M    = 32;
  localparam int KMAX = 4;

  logic               Clk = 1'b0;
  logic               reset;
  logic               start;
  logic [2:0]         kk;
  logic signed [31:0] thr;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int t0, dcyc, wfirst, nw0, nw1, bfirst, blast, dseen;

  logic signed [N-1:0] mem [M];
  logic signed [31:0]  r0 [M];
  logic signed [15:0]  r1 [M];

  neo_engine_if #(.N(N), .M(M), .KMAX(KMAX), .OW(32)) b0 ();
  neo_engine_if #(.N(N), .M(M), .KMAX(KMAX), .OW(16)) b1 ();

  neo_engine #(.N(N), .M(M), .KMAX(KMAX), .OW(32)) u0 (
    .Clk(Clk), .reset(reset), .bus(b0.slave)
  );
  neo_engine #(.N(N), .M(M), .KMAX(KMAX), .OW(16)) u1 (
    .Clk(Clk), .reset(reset), .bus(b1.slave)
  );

  assign b0.start  = start;
  assign b1.start  = start;
  assign b0.k      = kk;
  assign b1.k      = kk;
  assign b0.thresh = thr;
  assign b1.thresh = thr[15:0];

  always #5 Clk = ~Clk;

  always_ff @(posedge Clk) begin
    cyc      <= cyc + 1;
    b0.rdata <= mem[b0.raddr];
    b1.rdata <= mem[b1.raddr];
  end

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_zero();
    for (int i = 0; i < M; i++) mem[i] = '0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < M; i++) mem[i] = 16'(i);
  endtask

  task automatic launch(input logic [2:0] kv,
                        input logic signed [31:0] tv);
    kk    = kv;
    thr   = tv;
    start = 1'b1;
    t0    = cyc;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic collect();
    dcyc = -1; wfirst = -1; nw0 = 0; nw1 = 0;
    bfirst = -1; blast = -1;
    for (int i = 0; i < M; i++) begin
      r0[i] = 'x;
      r1[i] = 'x;
    end
    for (int i = 0; i < 300; i++) begin
      if (b0.wen) begin
        r0[b0.waddr] = b0.wdata;
        if (b0.waddr == 0) wfirst = cyc;
        nw0++;
      end
      if (b1.wen) begin
        r1[b1.waddr] = b1.wdata;
        nw1++;
      end
      if (b0.busy) begin
        if (bfirst < 0) bfirst = cyc;
        blast = cyc;
      end
      if (b0.done) begin
        dcyc = cyc;
        break;
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    kk    = '0;
    thr   = '0;
    fill_zero();
    repeat (2) @(negedge Clk);
    check("rst_raddr", b0.raddr, 0);
    check("rst_wen", b0.wen, 0);
    check("rst_waddr", b0.waddr, 0);
    check("rst_wdata", b0.wdata, 0);
    check("rst_busy", b0.busy, 0);
    check("rst_done", b0.done, 0);
    check("rst_spikes", b0.spike_count, 0);
    check("rst_sat", b0.sat, 0);
    reset = 1'b1;
    @(negedge Clk);

    // ramp, k = 1: psi = 1 inside, 0 at both ends
    fill_ramp();
    launch(3'd1, 0);
    collect();
    check("k1_first_wr", wfirst, t0 + 5);
    check("k1_done", dcyc, t0 + 37);
    check("k1_busy_first", bfirst, t0 + 1);
    check("k1_busy_last", blast, t0 + 36);
    check("k1_nwrites", nw0, M);
    for (int n = 0; n < M; n++)
      check($sformatf("k1_psi[%0d]", n), r0[n],
            (n < 1 || n >= M - 1) ? 0 : 1);
    check("k1_spikes", b0.spike_count, 30);
    check("k1_sat", b0.sat, 0);
    check("k1_sat16", b1.sat, 0);
    check("k1_psi16[5]", r1[5], 1);
    check("k1_nwrites16", nw1, M);

    // ramp, k = 3, with a start pulse mid-frame
    launch(3'd3, 5);
    kk    = 3'd1;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    collect();
    check("k3_first_wr", wfirst, t0 + 7);
    check("k3_done", dcyc, t0 + 39);
    check("k3_nwrites", nw0, M);
    for (int n = 0; n < M; n++)
      check($sformatf("k3_psi[%0d]", n), r0[n],
            (n < 3 || n >= M - 3) ? 0 : 9);
    check("k3_spikes", b0.spike_count, 26);

    // extremes: exact at OW = 32, saturating at OW = 16
    fill_zero();
    mem[9]  = 16'sh7fff;
    mem[10] = 16'sh8000;
    mem[11] = 16'sh8000;
    launch(3'd1, 0);
    collect();
    check("ext_psi[8]", r0[8], 0);
    check("ext_psi[9]", r0[9], 1073676289);
    check("ext_psi[10]", r0[10], 2147450880);
    check("ext_psi[11]", r0[11], 1073741824);
    check("ext_psi[12]", r0[12], 0);
    check("ext_sat", b0.sat, 0);
    check("ext_spikes", b0.spike_count, 3);
    check("ext16_psi[9]", r1[9], 32767);
    check("ext16_psi[10]", r1[10], 32767);
    check("ext16_psi[12]", r1[12], 0);
    check("ext16_sat", b1.sat, 1);
    check("ext16_spikes", b1.spike_count, 3);

    // single impulse
    fill_zero();
    mem[10] = 16'sd100;
    launch(3'd1, 0);
    collect();
    check("imp_psi[9]", r0[9], 0);
    check("imp_psi[10]", r0[10], 10000);
    check("imp_psi[11]", r0[11], 0);
    check("imp_spikes", b0.spike_count, 1);
    check("imp_sat", b0.sat, 0);

    // k = 0 runs as k = 1
    fill_ramp();
    launch(3'd0, 0);
    collect();
    check("k0_first_wr", wfirst, t0 + 5);
    check("k0_done", dcyc, t0 + 37);
    check("k0_psi[0]", r0[0], 0);
    check("k0_psi[1]", r0[1], 1);
    check("k0_psi[30]", r0[30], 1);
    check("k0_psi[31]", r0[31], 0);

    // k = 7 runs as k = 4
    launch(3'd7, 0);
    collect();
    check("k7_first_wr", wfirst, t0 + 8);
    check("k7_done", dcyc, t0 + 40);
    check("k7_psi[3]", r0[3], 0);
    check("k7_psi[4]", r0[4], 16);
    check("k7_psi[27]", r0[27], 16);
    check("k7_psi[28]", r0[28], 0);
    check("k7_spikes", b0.spike_count, 24);

    // back-to-back start in the done cycle
    launch(3'd1, 0);
    check("b2b_busy", b0.busy, 1);
    check("b2b_spikes_clr", b0.spike_count, 0);
    collect();
    check("b2b_first_wr", wfirst, t0 + 5);
    check("b2b_done", dcyc, t0 + 37);
    check("b2b_spikes", b0.spike_count, 30);

    // reset asserted mid-frame aborts without done
    @(negedge Clk);
    launch(3'd2, 0);
    repeat (10) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    check("mid_raddr", b0.raddr, 0);
    check("mid_wen", b0.wen, 0);
    check("mid_waddr", b0.waddr, 0);
    check("mid_wdata", b0.wdata, 0);
    check("mid_busy", b0.busy, 0);
    check("mid_spikes", b0.spike_count, 0);
    check("mid_sat16", b1.sat, 0);
    @(negedge Clk);
    reset = 1'b1;
    dseen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (b0.done || b0.busy) dseen = 1;
    end
    check("mid_no_done", dseen, 0);
    launch(3'd1, 0);
    collect();
    check("post_done", dcyc, t0 + 37);
    check("post_psi[15]", r0[15], 1);
    check("post_spikes", b0.spike_count, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
